// File: rtl/mccu_quota_irq_ctrl_pkg.sv
// Shared types and helpers for the MCCU quota interrupt controller.
// Optional per-core overrun counters are enabled with MCCU_OVERRUN_CNT_EN.
package mccu_irq_pkg;

   // Per-core interrupt life cycle: armed, fired (pending), waiting for a quota reload.
   typedef enum logic [1:0] {
      StArmed      = 2'd0,
      StFired      = 2'd1,
      StWaitReload = 2'd2
   } irq_state_e;

   // Width of the core id output; at least one bit even for a single core.
   function automatic int unsigned core_id_w(input int unsigned n_cores);
      return (n_cores <= 1) ? 1 : $clog2(n_cores);
   endfunction

   // Saturation value of a counter of the given width (widths of 32 and above pin to all ones).
   function automatic logic [31:0] cnt_sat_val(input int unsigned width);
      return (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
   endfunction

endpackage

// File: rtl/mccu_quota_irq_ctrl_if.sv
// Bundle of the MCCU-side inputs and the interrupt outputs of mccu_quota_irq_ctrl.
// master drives the MCCU/register inputs, slave is the controller itself.
interface mccu_quota_irq_ctrl_if
   import mccu_irq_pkg::*;
#(
   parameter int unsigned N_CORES    = 1,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned CNT_WIDTH  = 16
) ();

   localparam int unsigned CORE_ID_W = core_id_w(N_CORES);

   logic                            enable_i;
   logic [N_CORES-1:0]              interruption_quota_i;
   logic [N_CORES*DATA_WIDTH-1:0]   quota_i;
   logic [N_CORES-1:0]              irq_mask_i;
   logic [N_CORES-1:0]              irq_clear_i;
   logic [N_CORES-1:0]              irq_pending_o;
   logic                            irq_o;
   logic [CORE_ID_W-1:0]            irq_core_id_o;
   logic [N_CORES*CNT_WIDTH-1:0]    overrun_cnt_o;

   modport master (
      output enable_i, interruption_quota_i, quota_i, irq_mask_i, irq_clear_i,
      input  irq_pending_o, irq_o, irq_core_id_o, overrun_cnt_o
   );

   modport slave (
      input  enable_i, interruption_quota_i, quota_i, irq_mask_i, irq_clear_i,
      output irq_pending_o, irq_o, irq_core_id_o, overrun_cnt_o
   );

endinterface

// File: rtl/mccu_quota_irq_ctrl_core_fsm.sv
// One core's interrupt FSM: sticky pending bit, storm suppression until a non-zero reload,
// and an optional saturating overrun counter (MCCU_OVERRUN_CNT_EN).
module mccu_irq_core_fsm
   import mccu_irq_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  enable_i,
   input  logic                  intr_i,
   input  logic [DATA_WIDTH-1:0] quota_i,
   input  logic                  clear_i,
   output logic                  pending_o,
   output logic [CNT_WIDTH-1:0]  cnt_o
);

   irq_state_e state_q, state_d;

   // Next-state logic; a clear in StArmed is ignored so a coincident fire always wins.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StArmed:      if (enable_i && intr_i) state_d = StFired;
         StFired:      if (clear_i) state_d = StWaitReload;
         StWaitReload: if ((quota_i != '0) && !intr_i) state_d = StArmed;
         default:      state_d = StArmed;
      endcase
   end

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= StArmed;
      else       state_q <= state_d;
   end

   assign pending_o = (state_q == StFired);

`ifdef MCCU_OVERRUN_CNT_EN
   localparam logic [CNT_WIDTH-1:0] CntMax = CNT_WIDTH'(cnt_sat_val(CNT_WIDTH));

   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   // Counter next value: restart on a new fire, count while overrun, hold in StArmed.
   always_comb begin
      cnt_d = cnt_q;
      if ((state_q == StArmed) && (state_d == StFired)) begin
         cnt_d = '0;
      end else if ((state_q != StArmed) && enable_i && (cnt_q != CntMax)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;
`else
   assign cnt_o = '0;
`endif

endmodule

// File: rtl/mccu_quota_irq_ctrl.sv
// Aggregates per-core MCCU quota interrupts into one maskable CPU interrupt with the
// lowest-index active core id. Optional overrun counters: define MCCU_OVERRUN_CNT_EN.
module mccu_quota_irq_ctrl
   import mccu_irq_pkg::*;
#(
   parameter int unsigned N_CORES    = 1,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   mccu_quota_irq_ctrl_if.slave  bus
);

   localparam int unsigned CORE_ID_W = core_id_w(N_CORES);

   logic [N_CORES-1:0] pending;
   logic [N_CORES-1:0] active;

   for (genvar c = 0; c < N_CORES; c++) begin : g_core
      mccu_irq_core_fsm #(
         .DATA_WIDTH (DATA_WIDTH),
         .CNT_WIDTH  (CNT_WIDTH)
      ) u_fsm (
         .clk_i     (clk_i),
         .rst_i     (rst_i),
         .enable_i  (bus.enable_i),
         .intr_i    (bus.interruption_quota_i[c]),
         .quota_i   (bus.quota_i[c*DATA_WIDTH +: DATA_WIDTH]),
         .clear_i   (bus.irq_clear_i[c]),
         .pending_o (pending[c]),
         .cnt_o     (bus.overrun_cnt_o[c*CNT_WIDTH +: CNT_WIDTH])
      );
   end

   // Mask acts combinationally so mask writes reach irq_o in the same cycle.
   assign active            = pending & ~bus.irq_mask_i;
   assign bus.irq_pending_o = pending;
   assign bus.irq_o         = |active;

   // Fixed-priority encoder; scanning downwards leaves the lowest active index.
   always_comb begin
      bus.irq_core_id_o = '0;
      for (int c = N_CORES - 1; c >= 0; c--) begin
         if (active[c]) bus.irq_core_id_o = CORE_ID_W'(c);
      end
   end

endmodule

// File: doc/mccu_quota_irq_ctrl.md
Name: mccu_quota_irq_ctrl

Overview:
- Downstream consumer of the MCCU per-core quota interrupt and remaining-quota outputs.
- Converts the level-type quota-exhaustion interrupts into sticky, maskable, software-clearable pending bits.
- Suppresses re-firing until software reloads a non-zero quota, avoiding interrupt storms.
- Aggregates all cores onto one CPU interrupt line with the lowest-index core id; optionally measures overrun duration per core.

Parameters:
- N_CORES, 1, number of monitored cores; must match the MCCU instance.
- DATA_WIDTH, 32, width of the quota values fed from the MCCU.
- CNT_WIDTH, 16, width of each per-core overrun counter.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous active-high reset.
- enable_i  input  1  MCCU enable (same signal that drives the MCCU); gates new fires and counting.
- interruption_quota_i  input  N_CORES  per-core level from the MCCU, high = consumed quota exceeds available quota.
- quota_i  input  N_CORES*DATA_WIDTH  per-core internal quota from the MCCU; core c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
- irq_mask_i  input  N_CORES  1 = core masked from irq_o; pending bit still sets.
- irq_clear_i  input  N_CORES  write-1-to-clear pulse per core, from the register wrapper.
- irq_pending_o  output  N_CORES  sticky pending status, independent of mask.
- irq_o  output  1  aggregated interrupt.
- irq_core_id_o  output  CORE_ID_W  lowest-index unmasked pending core; CORE_ID_W = max(1, $clog2(N_CORES)).
- overrun_cnt_o  output  N_CORES*CNT_WIDTH  per-core overrun cycle count.

Behaviour:
- Reset (rst_i high, asynchronous): every core FSM = ARMED; irq_pending_o = 0, irq_o = 0, irq_core_id_o = 0, overrun_cnt_o = 0.
- Per-core FSM, 3 states:
  - ARMED -> FIRED when enable_i && interruption_quota_i[c].
  - FIRED -> WAIT_RELOAD when irq_clear_i[c].
  - WAIT_RELOAD -> ARMED when quota_i[c] != 0 && !interruption_quota_i[c].
  - All other cases: hold state.
- irq_pending_o[c] = (state == FIRED), registered. Latency: 1 cycle from the interruption input sampled high to the pending bit high.
- irq_clear_i[c] is ignored in ARMED and WAIT_RELOAD.
- A clear arriving in the same cycle as the fire condition in ARMED is ignored; the fire wins and the FSM enters FIRED.
- enable_i low:
  - ARMED cannot fire.
  - FIRED holds, and clear still works.
  - WAIT_RELOAD can still re-arm; re-arm is independent of enable_i.
- irq_o = |(irq_pending_o & ~irq_mask_i), combinational from registered state and mask.
- Mask changes take effect on irq_o in the same cycle.
- irq_core_id_o: fixed priority, lowest index wins; 0 when irq_o = 0.
- A quota of 0 with the interruption input low in WAIT_RELOAD does not re-arm; a non-zero reload is required.

Optional Feature:
- Macro: MCCU_OVERRUN_CNT_EN.
- Defined:
  - Per-core counter clears to 0 on the ARMED->FIRED transition.
  - Increments by 1 each cycle the core is in FIRED or WAIT_RELOAD with enable_i high.
  - Saturates at 2^CNT_WIDTH-1 with no wrap.
  - Holds its value in ARMED so software can read the last overrun.
- Undefined: no counter registers; overrun_cnt_o tied to 0.

Decomposition:
- Package mccu_irq_pkg:
  - state enum (ARMED = 2'd0, FIRED = 2'd1, WAIT_RELOAD = 2'd2);
  - CORE_ID_W computation function;
  - counter saturation constant helper.
- Sub-module mccu_irq_core_fsm: one core's FSM, pending bit and optional counter; generated N_CORES times.
- Top level holds the priority encoder and output OR.

Test Plan:
- Basic fire/clear, N_CORES=2, enable=1:
  - interruption_quota_i=2'b01 at cycle 5 -> irq_pending_o=01 and irq_o=1 at cycle 6, irq_core_id_o=0.
  - irq_clear_i=01 -> irq_pending_o=00 next cycle.
- Storm suppression: after a clear, interruption stays high and quota_i[0]=0 for 10 cycles -> no re-fire. quota_i[0]=100 with interruption low -> ARMED; a following interruption high -> fires again.
- Priority/mask: cores 0 and 1 both fire with irq_mask_i=01 -> irq_o=1, irq_core_id_o=1, irq_pending_o=11. Unmasking -> irq_core_id_o=0 the same cycle.
- Enable gating: enable_i=0 with interruption high -> no pending. Raise enable_i -> pending one cycle later.
- Simultaneous fire and clear in ARMED -> FIRED, pending=1. Assert rst_i mid-FIRED -> all outputs 0 immediately, without waiting for a clock.
- MCCU_OVERRUN_CNT_EN, CNT_WIDTH=4, enable=1:
  - fire, clear after 5 cycles in FIRED, reload after 3 more cycles -> overrun_cnt_o[0]=8 and holds.
  - 20-cycle overrun -> count saturates at 15.
